// File: rtl/dmem_responder.sv
// Wait-state data memory responder: one request in flight, IDLE -> WAIT -> RESP.
// Define DMEM_SUBWORD_EN to enable byte/half accesses; otherwise every access is a word.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] LIMIT    = 32'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem_q [DEPTH];

  logic        accept, enter_resp, idle;
  logic        op_we, op_uns, op_err, misaligned;
  logic [31:0] op_addr, op_wdata;
  logic [1:0]  op_size;
  logic [AW-1:0] idx;
  logic [31:0] rd_word, rd_shift, load_val, wr_data, merged;
  logic [3:0]  be;

  assign idle   = (state_q == S_IDLE);
  assign accept = idle && req_valid;

  // With zero wait states the commit edge is the accept edge, so operands come straight from the port.
  assign op_we    = idle ? req_we    : we_q;
  assign op_addr  = idle ? req_addr  : addr_q;
  assign op_wdata = idle ? req_wdata : wdata_q;

`ifdef DMEM_SUBWORD_EN
  logic [1:0] size_q;
  logic       uns_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      size_q <= '0;
      uns_q  <= 1'b0;
    end else if (accept) begin
      size_q <= req_size;
      uns_q  <= req_unsigned;
    end
  end

  assign op_size = idle ? req_size     : size_q;
  assign op_uns  = idle ? req_unsigned : uns_q;
`else
  logic unused_subword;
  assign unused_subword = ^{req_size, req_unsigned};
  assign op_size = 2'b10;
  assign op_uns  = 1'b0;
`endif

  assign idx      = op_addr[AW+1:2];
  assign rd_word  = mem_q[idx];
  assign rd_shift = rd_word >> {op_addr[1:0], 3'b000};

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b1111;
    wr_data    = op_wdata;
    load_val   = rd_word;
    case (op_size)
      2'b00: begin
        be       = 4'b0001 << op_addr[1:0];
        wr_data  = {4{op_wdata[7:0]}};
        load_val = op_uns ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      2'b01: begin
        misaligned = op_addr[0];
        be         = op_addr[1] ? 4'b1100 : 4'b0011;
        wr_data    = {2{op_wdata[15:0]}};
        load_val   = op_uns ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
      default: misaligned = |op_addr[1:0];
    endcase
  end

  assign op_err = (op_addr >= LIMIT) || misaligned;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wr_data[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        if (WAIT_CYCLES == 0) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = op_err;
      rdata_d = (op_err || op_we) ? '0 : load_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Storage is not reset; gating with reset keeps a zero-wait accept from committing during reset.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && op_we && !op_err) begin
      mem_q[idx] <= merged;
    end
  end

  assign req_ready = idle;
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = !idle;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: transaction-level memory model plus directed literal checks.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WAITC = 2;

  logic        clk, reset;
  logic        req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;

  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [1:0]  b_req_size;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0] ref_mem [DEPTH];
  bit        m_busy = 0, m_resp = 0, m_err = 0;
  bit [31:0] m_rdata = 0;
  int        m_left = 0;
  bit        m_we, m_uns;
  bit [31:0] m_addr, m_wdata;
  bit [1:0]  m_size;

  function automatic int nbytes(input bit [1:0] sz);
`ifdef DMEM_SUBWORD_EN
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`else
    return 4;
`endif
  endfunction

  task automatic model_commit(input bit we, input bit [31:0] addr, input bit [31:0] wdata,
                              input bit [1:0] sz, input bit uns);
    int        nb, off;
    bit        bad;
    bit [31:0] word, mask, val;
    nb  = nbytes(sz);
    bad = (addr >= 32'(4 * DEPTH)) || ((addr % nb) != 0);
    m_resp <= 1'b1;
    m_err  <= bad;
    if (bad) begin
      m_rdata <= '0;
    end else begin
      word = ref_mem[addr / 4];
      off  = int'(addr % 4);
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      if (we) begin
        ref_mem[addr / 4] <= (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
        m_rdata <= '0;
      end else begin
        val = (word >> (8 * off)) & mask;
        if (!uns && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
        m_rdata <= val;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy  <= 1'b0;
      m_resp  <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
      m_left  <= 0;
    end else if (m_resp) begin
      if (rsp_ready) begin
        m_resp <= 1'b0;
        m_busy <= 1'b0;
      end
    end else if (m_busy) begin
      if (m_left == 1) model_commit(m_we, m_addr, m_wdata, m_size, m_uns);
      else             m_left <= m_left - 1;
    end else if (req_valid) begin
      m_busy  <= 1'b1;
      m_we    <= req_we;
      m_addr  <= req_addr;
      m_wdata <= req_wdata;
      m_size  <= req_size;
      m_uns   <= req_unsigned;
      m_left  <= WAITC;
      if (WAITC == 0) model_commit(req_we, req_addr, req_wdata, req_size, req_unsigned);
    end
  end

  // Compare process for instance A.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_resp});
      if (m_resp || !reset) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input bit we, input bit [31:0] addr, input bit [31:0] wdata, input bit [1:0] sz,
                        input bit uns, input int hold, input bit junk,
                        output bit [31:0] rd, output bit er, output int lat);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #2; n++; end
    if (n >= 50) fail_now("accept_wait");
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = sz; req_unsigned = uns;
    @(posedge clk); #2;
    lat = 1;
    req_valid = junk; req_we = 1'b1; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #2; lat++; n++; end
    if (n >= 40) fail_now("rsp_wait");
    rd = rsp_rdata;
    er = rsp_err;
    repeat (hold) begin
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      @(posedge clk); #2;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("latency", 32'(lat), 32'(WAITC + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit [31:0] rd, addr;
    bit        er;
    int        lat, r;

    reset = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_size = 2'd2; req_unsigned = 0; rsp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_req_size = 2'd2; b_req_unsigned = 0;
    b_rsp_ready = 0;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;

    // Fill storage so later loads are defined.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      do_req(1'b1, 32'(4 * i), (i == 0) ? 32'h0BAD_F00D : (i == 8) ? 32'h1111_1111 : $urandom,
             2'd2, 1'b0, 0, 1'b0, rd, er, lat);
    end

    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, 1'b0, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd, er, lat);
    chk("lw_10", rd, 32'hDEAD_BEEF);

`ifdef DMEM_SUBWORD_EN
    do_req(1'b1, 32'h11, 32'h0000_0080, 2'd0, 1'b0, 0, 1'b0, rd, er, lat);
    do_req(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd, er, lat);
    chk("lw_after_sb", rd, 32'hDEAD_80EF);
    do_req(1'b0, 32'h11, 32'd0, 2'd0, 1'b0, 0, 1'b0, rd, er, lat);
    chk("lb_signed", rd, 32'hFFFF_FF80);
    do_req(1'b0, 32'h11, 32'd0, 2'd0, 1'b1, 0, 1'b0, rd, er, lat);
    chk("lbu", rd, 32'h0000_0080);
`endif

    do_req(1'b0, 32'h12, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd, er, lat);
    chk("lw_mis_err", {31'd0, er}, 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
    do_req(1'b1, 32'h100, 32'hCAFE_F00D, 2'd2, 1'b0, 0, 1'b0, rd, er, lat);
    chk("sw_oor_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 32'h0, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd, er, lat);
    chk("lw_0_unchanged", rd, 32'h0BAD_F00D);

    // Response held for 5 cycles with a competing request asserted.
    do_req(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 5, 1'b1, rd, er, lat);
`ifdef DMEM_SUBWORD_EN
    chk("hold_rdata", rd, 32'hDEAD_80EF);
`else
    chk("hold_rdata", rd, 32'hDEAD_BEEF);
`endif

    // Reset during WAIT drops the store.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_size = 2'd2;
    @(posedge clk); #2;
    req_valid = 1'b0;
    chk("inflight_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    do_req(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 0, 1'b0, rd, er, lat);
    chk("lw_20_prior", rd, 32'h1111_1111);

    // Zero-wait instance: single-cycle latency and back-to-back accepts every two cycles.
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'hA5A5_0001; b_rsp_ready = 1'b1;
    @(posedge clk); #2;
    b_req_valid = 1'b0;
    chk("b_lat1_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_store_err", {31'd0, b_rsp_err}, 32'd0);
    chk("b_store_rdata", b_rsp_rdata, 32'd0);
    @(posedge clk); #2;
    chk("b_idle_ready", {31'd0, b_req_ready}, 32'd1);
    b_req_valid = 1'b1; b_req_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      chk("b_b2b_valid", {31'd0, b_rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("b_b2b_rdata", b_rsp_rdata, 32'hA5A5_0001);
    end
    b_req_valid = 1'b0; b_rsp_ready = 1'b0;

    // Randomized traffic against the model.
    for (int t = 0; t < 250; t++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      addr = 32'(4 * DEPTH) + $urandom_range(0, 255);
      else if (r == 1) addr = $urandom;
      else             addr = $urandom_range(0, 4 * DEPTH - 1);
      do_req(1'($urandom), addr, $urandom, 2'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom), rd, er, lat);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end

    @(posedge clk); #2;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning storage size in 32-bit words (power of two, >= 4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each response (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned for sub-word stores.
REQ-010 SHALL have port req_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-011 SHALL have port req_unsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-012 SHALL have port rsp_valid  output  1  response presented.
REQ-013 SHALL have port rsp_ready  input  1  initiator accepts response.
REQ-014 SHALL have port rsp_rdata  output  32  load data, extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  access was misaligned or out of range.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = (state == IDLE); rsp_valid = (state == RESP).
REQ-018 SHALL accept a request on an edge with req_valid && req_ready and latch we, addr, wdata, size, unsigned.
REQ-019 SHALL, on accept, go to RESP if WAIT_CYCLES == 0, else go to WAIT and load the wait counter with WAIT_CYCLES-1.
REQ-020 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where it is 0; rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 SHALL commit stores and capture load data on the edge that enters RESP (the commit edge), never earlier.
REQ-022 SHALL hold rsp_rdata and rsp_err stable while in RESP and return to IDLE on the edge with rsp_ready high; no request is accepted in that same edge.
REQ-023 SHALL flag rsp_err when addr >= 4*DEPTH, or half access with addr[0]=1, or word access with addr[1:0] != 0.
REQ-024 SHALL, on error, suppress the store and return rsp_rdata = 0.
REQ-025 SHALL index storage with addr[log2(DEPTH)+1:2]; byte lane = addr[1:0], half lane = addr[1].
REQ-026 SHALL merge sub-word stores into only the addressed lanes, leaving other bytes unchanged.
REQ-027 SHALL extend sub-word load data to 32 bits per req_unsigned.
REQ-028 SHALL ignore req_valid while not in IDLE.

Reset
REQ-029 SHALL, while reset is low, force state IDLE, wait counter 0, rsp_rdata 0, rsp_err 0; thus req_ready 1, rsp_valid 0, busy 0.
REQ-030 SHALL drop an in-flight access if reset asserts before its commit edge; the store does not occur.
REQ-031 SHALL leave storage contents unaffected by reset.

Configuration
REQ-032 SHALL support macro DMEM_SUBWORD_EN: when defined, byte/half accesses operate per REQ-025..027.
REQ-033 SHALL, when DMEM_SUBWORD_EN is undefined, ignore req_size and req_unsigned, treat every access as word, and apply the word misalignment rule.

Verification
REQ-034 SHALL cover: WAIT_CYCLES=2, store word 0xDEADBEEF @0x10, rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_rdata 0, rsp_err 0; load @0x10 -> 0xDEADBEEF.
REQ-035 SHALL cover (DMEM_SUBWORD_EN): store byte 0x80 @0x11 over 0xDEADBEEF -> word reads 0xDEAD80EF; signed byte load @0x11 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 SHALL cover: word load @0x12 -> rsp_err 1, rdata 0; word store @0x100 (DEPTH 64) -> rsp_err 1, no storage change.
REQ-037 SHALL cover: rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready 0, second req_valid ignored until handshake.
REQ-038 SHALL cover: reset pulsed low during WAIT of store 0x12345678 @0x20 -> outputs at reset values, later load @0x20 returns prior contents.
REQ-039 SHALL cover: WAIT_CYCLES=0 -> rsp_valid 1 cycle after accept; back-to-back requests accepted every 2 cycles with rsp_ready tied high.
